// File: rtl/apb_regfile_slave.sv
// APB completer holding a small bank of WIDTH-bit registers.
// Register 0 is exported as a live control word. Each access phase lasts
// WAIT_STATES+1 cycles. Addresses at or beyond NUM_REGS complete with PSLVERR.
// All response outputs are registered, so the completion response is
// prepared on the edge before the completion cycle.
module apb_regfile_slave #(
    parameter int WIDTH       = 8,
    parameter int ADDR_W      = 4,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [WIDTH-1:0]  pwdata,
    output logic [WIDTH-1:0]  prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [WIDTH-1:0]  reg0_out
);

    // SETUP is the first bus cycle after the address was captured.
    // ACCESS covers the remaining access-phase cycles.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);
    localparam logic [3:0]      WS_L       = 4'(WAIT_STATES);
    localparam logic            WS_ZERO_L  = (WAIT_STATES == 0);

    state_t            state_r, state_s;
    logic [3:0]        cnt_r, cnt_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic              write_r, write_s;
    logic [WIDTH-1:0]  wdata_r, wdata_s;
    logic [WIDTH-1:0]  regs_r [NUM_REGS];
    logic [WIDTH-1:0]  prdata_r, prdata_s;
    logic              pready_r, pready_s;
    logic              pslverr_r, pslverr_s;
    logic              commit_s;
    logic              start_s;
    logic              load_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic              sel_write_s;
    logic              sel_valid_s;
    logic [WIDTH-1:0]  sel_rdata_s;

    // A setup phase on the bus means the response is for the new address, otherwise for the captured one
    always_comb begin
        if (psel && !penable) begin
            sel_addr_s  = paddr;
            sel_write_s = pwrite;
        end else begin
            sel_addr_s  = addr_r;
            sel_write_s = write_r;
        end
    end

    // Range check and read mux for the transfer whose response may be loaded this cycle
    always_comb begin
        sel_valid_s = ({1'b0, sel_addr_s} < NUM_REGS_L);
        sel_rdata_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            sel_rdata_s = (sel_addr_s == ADDR_W'(i)) ? regs_r[i] : sel_rdata_s;
        end
    end

    // Next-state, capture and registered-response computation
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        addr_s    = addr_r;
        write_s   = write_r;
        wdata_s   = wdata_r;
        prdata_s  = '0;
        pready_s  = 1'b0;
        pslverr_s = 1'b0;
        commit_s  = 1'b0;
        start_s   = 1'b0;
        load_s    = 1'b0;

        if (pready_r) begin
            // Completion cycle: a good write lands on the closing edge
            commit_s = write_r && !pslverr_r;
            state_s  = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (psel && !penable) begin
                        start_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SETUP, ST_ACCESS: begin
                    if (!psel) begin
                        state_s = ST_IDLE;
                    end else if (!penable) begin
                        // Requester restarted: pending transfer is dropped
                        start_s = 1'b1;
                    end else begin
                        cnt_s   = cnt_r + 4'd1;
                        state_s = ST_ACCESS;
                        load_s  = ((cnt_r + 4'd1) == WS_L);
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end

        if (start_s) begin
            state_s = ST_SETUP;
            cnt_s   = 4'd0;
            addr_s  = paddr;
            write_s = pwrite;
            wdata_s = pwdata;
            load_s  = WS_ZERO_L;
        end else begin
            start_s = 1'b0;
        end

        if (load_s) begin
            pready_s  = 1'b1;
            pslverr_s = !sel_valid_s;
            prdata_s  = (sel_valid_s && !sel_write_s) ? sel_rdata_s : '0;
        end else begin
            pready_s  = 1'b0;
        end
    end

    // Control state, captured transfer and response registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            addr_r    <= '0;
            write_r   <= 1'b0;
            wdata_r   <= '0;
            prdata_r  <= '0;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            addr_r    <= addr_s;
            write_r   <= write_s;
            wdata_r   <= wdata_s;
            prdata_r  <= prdata_s;
            pready_r  <= pready_s;
            pslverr_r <= pslverr_s;
        end
    end

    // Register bank, written only by a successful completed write
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (commit_s) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (addr_r == ADDR_W'(i)) begin
                    regs_r[i] <= wdata_r;
                end
            end
        end
    end

    assign prdata   = prdata_r;
    assign pready   = pready_r;
    assign pslverr  = pslverr_r;
    assign reg0_out = regs_r[0];

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Scoreboard bench for apb_regfile_slave: three instances with WAIT_STATES
// of 1, 0 and 3, directed scenarios followed by random transfers.
module tb_apb_regfile_slave;

    localparam int W  = 8;
    localparam int AW = 4;
    localparam int NR = 8;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [NI-1:0]   psel, penable, pwrite, pready, pslverr;
    logic [AW-1:0]   paddr    [NI];
    logic [W-1:0]    pwdata   [NI];
    logic [W-1:0]    prdata   [NI];
    logic [W-1:0]    reg0_out [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int WS_G = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        apb_regfile_slave #(.WIDTH(W), .ADDR_W(AW), .NUM_REGS(NR), .WAIT_STATES(WS_G)) u_dut (
            .clk(clk), .rst(rst), .psel(psel[g]), .penable(penable[g]), .pwrite(pwrite[g]),
            .paddr(paddr[g]), .pwdata(pwdata[g]), .prdata(prdata[g]), .pready(pready[g]),
            .pslverr(pslverr[g]), .reg0_out(reg0_out[g])
        );
    end

    function automatic int ws_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    endfunction

    typedef struct {
        int          g;
        logic        wr;
        logic [AW-1:0] addr;
        logic [W-1:0]  wdata;
        logic [W-1:0]  rdata;
        logic          err;
    } exp_t;

    exp_t         exp_q [$];
    exp_t         mon_e;
    logic [W-1:0] model    [NI][NR];
    logic [W-1:0] reg0_exp [NI];
    int           n_checks = 0;
    int           n_fail   = 0;
    bit           mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops an expectation whenever a completion is presented
    always @(negedge clk) begin
        if (mon_en) begin
            for (int g = 0; g < NI; g++) begin
                check($sformatf("reg0_out[%0d]", g), reg0_out[g], reg0_exp[g]);
                if (pready[g]) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("unexpected pready[%0d]", g), pready[g], 1'b0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check($sformatf("completion instance %0d", g), g, mon_e.g);
                        check($sformatf("prdata[%0d] addr %0d", g, mon_e.addr), prdata[g], mon_e.rdata);
                        check($sformatf("pslverr[%0d] addr %0d", g, mon_e.addr), pslverr[g], mon_e.err);
                        if (mon_e.wr && !mon_e.err && mon_e.addr == 0) reg0_exp[g] = mon_e.wdata;
                    end
                end else begin
                    check($sformatf("idle prdata[%0d]", g), prdata[g], 8'h00);
                    check($sformatf("idle pslverr[%0d]", g), pslverr[g], 1'b0);
                end
                if (!rst) reg0_exp[g] = 8'h00;
            end
        end
    end

    task automatic issue(input int g, input bit wr, input logic [AW-1:0] a, input logic [W-1:0] d);
        exp_t e;
        bit   v;
        v       = (a < NR);
        e.g     = g;
        e.wr    = wr;
        e.addr  = a;
        e.wdata = d;
        e.err   = !v;
        e.rdata = (v && !wr) ? model[g][a[2:0]] : 8'h00;
        exp_q.push_back(e);
        if (wr && v) model[g][a[2:0]] = d;
    endtask

    // Runs one transfer starting just after a rising edge; leaves psel high unless idle_after
    task automatic xfer(input int g, input bit wr, input logic [AW-1:0] a,
                        input logic [W-1:0] d, input bit idle_after);
        int n;
        bit done;
        issue(g, wr, a, d);
        psel = '0; penable = '0;
        psel[g] = 1'b1; pwrite[g] = wr; paddr[g] = a; pwdata[g] = d;
        @(posedge clk); #1;
        penable[g] = 1'b1;
        n = 0; done = 1'b0;
        while (!done && n < 32) begin
            @(negedge clk);
            n++;
            if (pready[g]) done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("pready timeout", done, 1'b1);
        check($sformatf("access length inst %0d", g), n, ws_of(g) + 1);
        @(posedge clk); #1;
        penable[g] = 1'b0;
        if (idle_after) psel[g] = 1'b0;
    endtask

    task automatic go_idle();
        psel = '0; penable = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0; psel = '0; penable = '0; pwrite = '0;
        for (int g = 0; g < NI; g++) begin
            paddr[g] = '0; pwdata[g] = '0; reg0_exp[g] = 8'h00;
            for (int r = 0; r < NR; r++) model[g][r] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1; mon_en = 1'b1; rst = 1'b1;
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check("reset pready", pready[g], 1'b0);
            check("reset pslverr", pslverr[g], 1'b0);
            check("reset prdata", prdata[g], 8'h00);
            check("reset reg0_out", reg0_out[g], 8'h00);
        end
        @(posedge clk); #1;

        // Write then read, one wait state
        xfer(0, 1'b1, 4'd2, 8'hA5, 1'b1);
        xfer(0, 1'b0, 4'd2, 8'h00, 1'b1);
        // Register 0 output, then untouched register reads reset value
        xfer(0, 1'b1, 4'd0, 8'h3C, 1'b1);
        @(negedge clk);
        check("reg0_out after write", reg0_out[0], 8'h3C);
        @(posedge clk); #1;
        xfer(0, 1'b0, 4'd1, 8'h00, 1'b1);
        // Out-of-range write and read, then full readback
        xfer(0, 1'b1, 4'd9, 8'hFF, 1'b1);
        xfer(0, 1'b0, 4'd9, 8'h00, 1'b1);
        for (int r = 0; r < NR; r++) xfer(0, 1'b0, 4'(r), 8'h00, 1'b1);
        // Zero wait states, back-to-back writes
        xfer(1, 1'b1, 4'd1, 8'h11, 1'b0);
        xfer(1, 1'b1, 4'd2, 8'h22, 1'b0);
        xfer(1, 1'b1, 4'd3, 8'h33, 1'b1);
        for (int r = 1; r <= 3; r++) xfer(1, 1'b0, 4'(r), 8'h00, 1'b0);
        go_idle();
        // Abort in the second access cycle, three wait states
        psel = '0; penable = '0;
        psel[2] = 1'b1; pwrite[2] = 1'b1; paddr[2] = 4'd4; pwdata[2] = 8'h77;
        @(posedge clk); #1; penable[2] = 1'b1;
        @(posedge clk); #1; psel[2] = 1'b0; penable[2] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        xfer(2, 1'b0, 4'd4, 8'h00, 1'b1);

        // Reset during the access phase of a read
        xfer(0, 1'b1, 4'd0, 8'h5A, 1'b1);
        psel[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 4'd0;
        @(posedge clk); #1; penable[0] = 1'b1; rst = 1'b0;
        @(posedge clk); #1; rst = 1'b1; psel = '0; penable = '0;
        for (int g = 0; g < NI; g++)
            for (int r = 0; r < NR; r++) model[g][r] = 8'h00;
        @(negedge clk);
        check("pready after reset", pready[0], 1'b0);
        check("reg0_out after reset", reg0_out[0], 8'h00);
        @(posedge clk); #1;
        xfer(0, 1'b0, 4'd0, 8'h00, 1'b1);

        // Random traffic across the instances
        for (int k = 0; k < 60; k++) begin
            xfer($urandom_range(0, NI-1), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 8'($urandom), 1'($urandom_range(0, 1)));
        end
        go_idle();
        for (int g = 0; g < NI; g++)
            for (int r = 0; r < NR; r++) xfer(g, 1'b0, 4'(r), 8'h00, 1'b1);

        repeat (4) @(posedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_regfile_slave.md
Name: apb_regfile_slave

Overview:
- APB completer that answers transfers issued by the bridge's APB requester side.
- Holds a small bank of WIDTH-bit registers. Register 0 is also driven out as a control word to downstream datapath blocks, such as the WIDTH-parameterised dff.
- Supports a programmable number of wait states and flags out-of-range addresses with PSLVERR.
- Sits on the APB side of the AHB-APB subsystem and is the target for the requester's environment.

Parameters:
- WIDTH, 8, data width of PWDATA/PRDATA and of each register.
- ADDR_W, 4, address width; word addresses, with no byte offset.
- NUM_REGS, 8, number of implemented registers; must be 1 to 2**ADDR_W.
- WAIT_STATES, 1, number of extra ACCESS cycles with PREADY low before completion; range 0 to 15.

Ports:
- clk  in  1  clock; every state element changes on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on the clk rising edge.
- psel  in  1  APB select.
- penable  in  1  APB enable; marks the access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  register index.
- pwdata  in  WIDTH  write data.
- prdata  out  WIDTH  read data; valid only in the cycle where PREADY=1 and the access is a read.
- pready  out  1  transfer complete.
- pslverr  out  1  error response; valid only with PREADY=1.
- reg0_out  out  WIDTH  live copy of register 0.

Behaviour:
- Reset (rst=0 at an edge):
  - All registers, prdata, pready, pslverr and reg0_out go to 0.
  - FSM goes to IDLE and the wait counter to 0.
  - Reset overrides any transfer in flight; no write commits on the reset edge.
- FSM has three states: IDLE, SETUP and ACCESS.
- IDLE:
  - psel=1 and penable=0 moves to SETUP.
  - paddr, pwrite and pwdata are captured in that cycle.
  - penable=1 without a prior setup cycle is ignored; the FSM stays in IDLE.
- SETUP lasts exactly one cycle.
  - Next state is ACCESS with counter=0.
  - If psel=0 in the following cycle, the FSM aborts to IDLE.
- ACCESS:
  - The requester must hold psel=1, penable=1 and stable paddr/pwrite/pwdata.
  - The access phase lasts exactly WAIT_STATES+1 cycles.
  - PREADY is low for the first WAIT_STATES cycles and high in the last one.
  - PREADY is registered. With WAIT_STATES=0, PREADY is high in the first ACCESS cycle.
- Completion cycle (PREADY=1):
  - Valid address (paddr < NUM_REGS) with write: the register updates on the closing edge. reg0_out reflects the new value from the next cycle. pslverr=0.
  - Valid address with read: prdata equals the register content. pslverr=0.
  - Invalid address (paddr >= NUM_REGS): pslverr=1 and prdata=0. A write is discarded and no register changes.
- Outputs outside the completion cycle: pready=0, pslverr=0, prdata=0.
- After completion:
  - If psel=1 and penable=0 in the next cycle, the FSM goes straight to SETUP (back-to-back transfers, no idle cycle required).
  - Otherwise it returns to IDLE.
- Abort: psel=0 during ACCESS before completion returns the FSM to IDLE. No register write occurs and pready stays 0.
- Protocol violation: penable=0 while psel=1 in ACCESS restarts the transfer as a new SETUP. The pending write is dropped.
- Reads have no side effects. Registers are retained across transfers.
- No write-to-read forwarding is needed: a read of the same register in the following transfer returns the committed value.

Test Plan:
- Write then read, WAIT_STATES=1:
  - Stimulus: write 0xA5 to addr 2, then read addr 2.
  - Response: each access phase is 2 cycles with pready high in the 2nd; the read returns prdata=0xA5 with pslverr=0.
- Register 0 output:
  - Stimulus: write 0x3C to addr 0.
  - Response: reg0_out=0x3C from the cycle after the completion edge.
  - Stimulus: then read addr 1.
  - Response: prdata=0x00 (reset value).
- Out-of-range address, NUM_REGS=8:
  - Stimulus: write 0xFF to addr 9, then read addr 9.
  - Response: both complete with pslverr=1 and prdata=0; a read of addrs 0-7 shows no register changed.
- Zero wait states and back-to-back, WAIT_STATES=0:
  - Stimulus: writes 0x11, 0x22, 0x33 to addrs 1, 2, 3 with no idle cycles between them.
  - Response: each transfer takes 2 cycles (SETUP + 1 ACCESS) with pready high in the ACCESS cycle; readback gives 0x11/0x22/0x33.
- Abort mid-access, WAIT_STATES=3:
  - Stimulus: write 0x77 to addr 4 and drop psel in the 2nd ACCESS cycle.
  - Response: pready never asserts; a subsequent read of addr 4 returns 0x00.
- Reset mid-operation:
  - Stimulus: after writing 0x5A to addr 0, start a read of addr 0 and pull rst=0 for one edge during ACCESS.
  - Response: pready=0, reg0_out=0x00, FSM in IDLE; a new read of addr 0 returns 0x00.
